// File: rtl/seg_display_rx.sv
// seg_display_rx
//   Reads a processor's 7-segment display output back into bytes. Each
//   {lsb,seg} sample is synchronised and debounced. A symbol that has been
//   stable for long enough is decoded to a hex nibble. High and low nibbles
//   are paired, chosen by the lsb flag, and the resulting byte is presented
//   on a valid/ready output.
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_seg_in[6:0]  segment pattern {g,f,e,d,c,b,a}
//   i_lsb_in       0 = high nibble shown, 1 = low nibble shown
//   i_byte_ready   consumer accepts o_byte_data when o_byte_valid is set
//   o_byte_data    assembled byte {hi,lo}
//   o_byte_valid   o_byte_data holds an unconsumed byte
//   o_sym_err      1-cycle pulse: stable pattern is not a hex digit or blank
//   o_overrun      1-cycle pulse: byte completed while the previous was held
module seg_display_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_seg_in,
  input  logic       i_lsb_in,
  input  logic       i_byte_ready,
  output logic [7:0] o_byte_data,
  output logic       o_byte_valid,
  output logic       o_sym_err,
  output logic       o_overrun
);

  localparam int              CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   SC = CW'(STABLE_CYCLES);

  typedef enum logic {S_IDLE, S_HAVE_HI} state_t;

  // Polarity is fixed before synchronising, so the reset value 0 means blank.
  logic [6:0] w_seg_fix;
  assign w_seg_fix = SEG_ACTIVE_LOW ? ~i_seg_in : i_seg_in;

  logic [SYNC_STAGES-1:0][7:0] r_sync;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= {i_lsb_in, w_seg_fix};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  logic [7:0] w_cur;
  assign w_cur = r_sync[SYNC_STAGES-1];

  // Debounce: run-length counter that saturates at SC. A symbol is accepted
  // only on the edge where the counter first reaches SC. When the counter is
  // already saturated on an equal sample, nothing is accepted, so a held
  // symbol is taken exactly once.
  logic [7:0]    r_prev;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_change;
  logic          w_accept;

  assign w_change = (w_cur != r_prev);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_change)         w_cnt_nxt = CW'(1);
    else if (r_cnt != SC) w_cnt_nxt = r_cnt + CW'(1);
  end

  assign w_accept = (w_cnt_nxt == SC) && (w_change || (r_cnt != SC));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= w_cur;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Hex decode; bit 4 flags a recognised digit.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h10; 7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12; 7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14; 7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16; 7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18; 7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A; 7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C; 7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E; 7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  logic [4:0] w_dec;
  logic       w_blank;
  assign w_dec   = decode(w_cur[6:0]);
  assign w_blank = (w_cur[6:0] == 7'h00);

  state_t     r_state;
  logic [3:0] r_hi;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_hi         <= '0;
      o_byte_data  <= '0;
      o_byte_valid <= 1'b0;
      o_sym_err    <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_sym_err <= 1'b0;
      o_overrun <= 1'b0;
      if (o_byte_valid && i_byte_ready) o_byte_valid <= 1'b0;

      if (w_accept && !w_blank) begin
        if (!w_dec[4]) begin
          o_sym_err <= 1'b1;
          r_state   <= S_IDLE;
        end else if (!w_cur[7]) begin
          // A high nibble in HAVE_HI overwrites the stored one, which resyncs
          // the pairing.
          r_hi    <= w_dec[3:0];
          r_state <= S_HAVE_HI;
        end else if (r_state == S_HAVE_HI) begin
          r_state <= S_IDLE;
          // The slot is free if it is empty or is being consumed on this edge.
          if (!o_byte_valid || i_byte_ready) begin
            o_byte_data  <= {r_hi, w_dec[3:0]};
            o_byte_valid <= 1'b1;
          end else begin
            o_overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_display_rx.sv
module tb_seg_display_rx;
  localparam int SC = 4;
  localparam logic [6:0] TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                      7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                      7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [6:0] seg = 7'h00;
  logic       lsb = 1'b0, ready = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid, sym_err, overrun;

  seg_display_rx dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_seg_in(seg), .i_lsb_in(lsb),
    .i_byte_ready(ready), .o_byte_data(byte_data), .o_byte_valid(byte_valid),
    .o_sym_err(sym_err), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int err_seen = 0, ov_seen = 0, lat = -1;

  // Scoreboard contents: bytes the consumer should receive, plus counts of
  // pending sym_err and overrun pulses.
  logic [7:0] q_byte[$];
  int exp_err = 0, exp_ov = 0;

  // Reference model. It works on whole runs of identical pin values and
  // ignores the synchroniser delay, because only the order of events matters.
  logic [7:0] m_prev = 8'h00;
  int         m_run = 0;
  logic       m_have = 1'b0, m_held = 1'b0;
  logic [3:0] m_hi = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_accept(input logic [7:0] v);
    int d;
    d = -1;
    for (int i = 0; i < 16; i++) if (TBL[i] == v[6:0]) d = i;
    if (v[6:0] == 7'h00) return;
    if (d < 0) begin
      exp_err++;
      m_have = 1'b0;
    end else if (!v[7]) begin
      m_hi   = 4'(d);
      m_have = 1'b1;
    end else if (m_have) begin
      m_have = 1'b0;
      if (ready || !m_held) begin
        q_byte.push_back({m_hi, 4'(d)});
        if (!ready) m_held = 1'b1;
      end else begin
        exp_ov++;
      end
    end
  endtask

  task automatic m_cycle(input logic [7:0] v);
    if (v == m_prev) m_run++;
    else begin m_run = 1; m_prev = v; end
    if (m_run == SC) m_accept(v);
  endtask

  task automatic m_reset();
    m_prev = 8'h00; m_run = 0; m_have = 1'b0; m_held = 1'b0;
  endtask

  // Hold one pattern for n edges and record how many edges pass before
  // byte_valid rises.
  task automatic drive(input logic [6:0] s, input logic l, input int n);
    logic bv0;
    bv0 = byte_valid;
    lat = -1;
    seg = s; lsb = l;
    for (int i = 0; i < n; i++) begin
      m_cycle({l, s});
      @(posedge clk); #1;
      if (lat < 0 && byte_valid && !bv0) lat = i + 1;
    end
  endtask

  task automatic set_ready(input logic r);
    ready = r;
    if (r) m_held = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
  endtask

  // Monitor: compares every handshake and pulse with the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid && ready) begin
        if (q_byte.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL byte_unexpected: got %0h expected none", byte_data);
        end else begin
          check("byte_data", byte_data, q_byte.pop_front());
        end
      end
      if (sym_err) begin
        err_seen++;
        n_tests++;
        if (exp_err == 0) begin
          n_fail++;
          $display("FAIL sym_err_unexpected: got pulse expected none");
        end else exp_err--;
      end
      if (overrun) begin
        ov_seen++;
        n_tests++;
        if (exp_ov == 0) begin
          n_fail++;
          $display("FAIL overrun_unexpected: got pulse expected none");
        end else exp_ov--;
      end
    end
  end

  initial begin
    int e0, o0, r, d, hold;
    logic [6:0] p;
    logic       l;

    // 1: reset with a digit on the pins, then release onto blank
    seg = 7'h7F; lsb = 1'b1; set_ready(1'b0);
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_byte_data", byte_data, 8'h00);
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_sym_err", sym_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1; m_reset();
    drive(7'h00, 1'b0, 10);
    check("t1_no_byte", byte_valid, 1'b0);
    check("t1_no_err", err_seen, 0);

    // 2: A5 with latency and a held output
    drive(7'h77, 1'b0, 8);
    drive(7'h6D, 1'b1, 8);
    check("t2_latency", lat, 6);
    check("t2_data", byte_data, 8'hA5);
    drive(7'h00, 1'b0, 4);
    check("t2_held", byte_valid, 1'b1);
    set_ready(1'b1); drive(7'h00, 1'b0, 1); set_ready(1'b0);
    check("t2_cleared", byte_valid, 1'b0);
    check("t2_data_kept", byte_data, 8'hA5);

    // 3: a low-nibble glitch that is too short is ignored
    e0 = err_seen;
    drive(7'h06, 1'b0, 8);
    drive(7'h5B, 1'b1, 3);
    drive(7'h06, 1'b0, 8);
    drive(7'h00, 1'b0, 8);
    check("t3_no_byte", byte_valid, 1'b0);
    check("t3_no_err", err_seen - e0, 0);

    // 4: bad pattern gives one error and returns to IDLE
    e0 = err_seen;
    drive(7'h7E, 1'b0, 10);
    check("t4_one_err", err_seen - e0, 1);
    drive(7'h3F, 1'b1, 8);
    drive(7'h00, 1'b0, 8);
    check("t4_no_byte", byte_valid, 1'b0);

    // 5: overrun while 12 is held
    o0 = ov_seen;
    drive(7'h06, 1'b0, 8); drive(7'h5B, 1'b1, 8); drive(7'h00, 1'b0, 8);
    drive(7'h4F, 1'b0, 8); drive(7'h66, 1'b1, 8); drive(7'h00, 1'b0, 4);
    check("t5_one_overrun", ov_seen - o0, 1);
    check("t5_data", byte_data, 8'h12);
    check("t5_valid", byte_valid, 1'b1);
    set_ready(1'b1); drive(7'h00, 1'b0, 2);

    // 6: high-nibble resync, then a reset in the middle of a byte
    drive(7'h06, 1'b0, 8); drive(7'h5B, 1'b0, 8); drive(7'h4F, 1'b1, 8);
    drive(7'h00, 1'b0, 6);
    drive(7'h66, 1'b0, 8);
    do_reset(1);
    drive(7'h6D, 1'b1, 8);
    drive(7'h00, 1'b0, 8);
    check("t6_no_byte_after_rst", byte_valid, 1'b0);
    check("t6_queue_empty", q_byte.size(), 0);

    // Random symbol streams; ready changes only while the pins are blank
    for (int blk = 0; blk < 12; blk++) begin
      drive(7'h00, 1'b0, 12);
      set_ready(1'($urandom_range(0, 1)));
      for (int k = 0; k < 30; k++) begin
        r = $urandom_range(0, 9);
        l = 1'($urandom_range(0, 1));
        if (r < 7) begin
          d = $urandom_range(0, 15);
          p = TBL[d];
        end else if (r == 7) begin
          p = 7'h00;
        end else begin
          p = 7'($urandom_range(1, 127));
          for (int i = 0; i < 16; i++) if (TBL[i] == p) p = 7'h7E;
        end
        hold = $urandom_range(1, 8);
        drive(p, l, hold);
      end
    end

    drive(7'h00, 1'b0, 12);
    set_ready(1'b1);
    drive(7'h00, 1'b0, 20);
    check("end_bytes_drained", q_byte.size(), 0);
    check("end_err_drained", exp_err, 0);
    check("end_ov_drained", exp_ov, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
